// File: rtl/ra_stack_if.sv
// Call/return strobe bundle between the decoder/PC side (master) and the return-address stack (slave).
interface ra_stack_if #(
   parameter int DEPTH = 8,
   parameter int AW    = 16
);
   logic                         push_in;
   logic                         pop_in;
   logic [AW-1:0]                pc_r_in;
   logic                         clr_err_in;
   logic [AW-1:0]                ra_out;
   logic                         empty_out;
   logic                         full_out;
   logic [$clog2(DEPTH+1)-1:0]   count_out;
   logic                         overflow_out;
   logic                         underflow_out;

   modport master (
      output push_in, pop_in, pc_r_in, clr_err_in,
      input  ra_out, empty_out, full_out, count_out, overflow_out, underflow_out
   );

   modport slave (
      input  push_in, pop_in, pc_r_in, clr_err_in,
      output ra_out, empty_out, full_out, count_out, overflow_out, underflow_out
   );
endinterface

// File: rtl/ra_stack.sv
// Hardware return-address stack for the fetch stage; pushes pc_r+1 on call, pops on return.
// Define RA_STACK_WRAP_EN for a circular stack that overwrites the oldest entry when full.
module ra_stack #(
   parameter int DEPTH = 8,
   parameter int AW    = 16
) (
   input  logic       clk,
   input  logic       rst,
   ra_stack_if.slave  bus
);

   localparam int SPW = $clog2(DEPTH);
   localparam int CW  = $clog2(DEPTH + 1);

   logic [AW-1:0]  mem [DEPTH];
   logic [SPW-1:0] sp, sp_nxt;
   logic [CW-1:0]  count, count_nxt;
   logic [SPW-1:0] top_idx, wr_idx;
   logic [AW-1:0]  push_val;
   logic           wr_en, is_empty, is_full;
   logic           unf_set, underflow;

   assign push_val = bus.pc_r_in + AW'(1);
   assign top_idx  = sp - SPW'(1);
   assign is_empty = (count == '0);
   assign is_full  = (count == CW'(DEPTH));

   always_comb begin
      sp_nxt    = sp;
      count_nxt = count;
      wr_en     = 1'b0;
      wr_idx    = sp;
      unf_set   = 1'b0;
      if (bus.push_in && bus.pop_in && !is_empty) begin
         // Tail call: replace the top entry in place.
         wr_en  = 1'b1;
         wr_idx = top_idx;
      end else if (bus.push_in) begin
         if (!is_full) begin
            wr_en     = 1'b1;
            sp_nxt    = sp + SPW'(1);
            count_nxt = count + CW'(1);
         end else begin
`ifdef RA_STACK_WRAP_EN
            wr_en  = 1'b1;
            sp_nxt = sp + SPW'(1);
`endif
         end
      end else if (bus.pop_in) begin
         if (!is_empty) begin
            sp_nxt    = top_idx;
            count_nxt = count - CW'(1);
         end else begin
            unf_set = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp        <= '0;
         count     <= '0;
         underflow <= 1'b0;
      end else begin
         sp        <= sp_nxt;
         count     <= count_nxt;
         underflow <= unf_set | (underflow & ~bus.clr_err_in);
      end
   end

   // Entry contents need no reset; ra_out is masked while the stack is empty.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= push_val;
      end
   end

`ifdef RA_STACK_WRAP_EN
   assign bus.overflow_out = 1'b0;
`else
   logic ovf_set, overflow;

   assign ovf_set = bus.push_in && !bus.pop_in && is_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else begin
         overflow <= ovf_set | (overflow & ~bus.clr_err_in);
      end
   end

   assign bus.overflow_out = overflow;
`endif

   assign bus.ra_out        = is_empty ? '0 : mem[top_idx];
   assign bus.empty_out     = is_empty;
   assign bus.full_out      = is_full;
   assign bus.count_out     = count;
   assign bus.underflow_out = underflow;

endmodule

// File: tb/tb_ra_stack.sv
// Scoreboard bench for ra_stack: stimulus queues the outputs expected in each driven cycle,
// a negedge monitor pops and compares them.
module tb_ra_stack;

   localparam int DEPTH = 8;
   localparam int AW    = 16;

   typedef struct {
      string       name;
      logic [15:0] ra;
      int          cnt;
      bit          ovf;
      bit          unf;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   exp_t exp_q[$];
   bit   ovf_held;

   ra_stack_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

   ra_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic compareField(input string name, input string what,
                               input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s.%s actual=%0h required=%0h", name, what, act, req);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      compareField(e.name, "ra_out",        32'(bus.ra_out),        32'(e.ra));
      compareField(e.name, "count_out",     32'(bus.count_out),     32'(e.cnt));
      compareField(e.name, "empty_out",     32'(bus.empty_out),     32'(e.cnt == 0));
      compareField(e.name, "full_out",      32'(bus.full_out),      32'(e.cnt == DEPTH));
      compareField(e.name, "overflow_out",  32'(bus.overflow_out),  32'(e.ovf));
      compareField(e.name, "underflow_out", 32'(bus.underflow_out), 32'(e.unf));
   endtask

   // Monitor: outputs are presented every cycle, compared mid-cycle away from the edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         checkOutput(exp_q.pop_front());
      end
   end

   task automatic pushExp(input string name, input logic [15:0] ra, input int cnt,
                          input bit ovf, input bit unf);
      exp_t e;
      e.name = name;
      e.ra   = ra;
      e.cnt  = cnt;
      e.ovf  = ovf;
      e.unf  = unf;
      exp_q.push_back(e);
   endtask

   // Drive one cycle of strobes and queue the outputs expected during that same cycle.
   task automatic applyStimulus(input bit push, input bit pop, input logic [15:0] pc,
                                input bit clr, input logic [15:0] ra, input int cnt,
                                input bit ovf, input bit unf, input string name);
      @(posedge clk);
      #1;
      bus.push_in    = push;
      bus.pop_in     = pop;
      bus.pc_r_in    = pc;
      bus.clr_err_in = clr;
      pushExp(name, ra, cnt, ovf, unf);
   endtask

   task automatic applyReset(input string name);
      @(posedge clk);
      #1;
      rst            = 1'b1;
      bus.push_in    = 1'b0;
      bus.pop_in     = 1'b0;
      bus.clr_err_in = 1'b0;
      pushExp(name, 16'h0000, 0, 1'b0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      checks         = 0;
      failures       = 0;
`ifdef RA_STACK_WRAP_EN
      ovf_held = 1'b0;
`else
      ovf_held = 1'b1;
`endif
      rst            = 1'b1;
      bus.push_in    = 1'b0;
      bus.pop_in     = 1'b0;
      bus.pc_r_in    = '0;
      bus.clr_err_in = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      applyStimulus(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, "reset_state");
      applyStimulus(1, 0, 16'h0010, 0, 16'h0000, 0, 0, 0, "push_0010");
      applyStimulus(0, 0, 16'h0000, 0, 16'h0011, 1, 0, 0, "after_push");
      applyStimulus(0, 1, 16'h0000, 0, 16'h0011, 1, 0, 0, "pop_single");

      applyStimulus(1, 0, 16'h0100, 0, 16'h0000, 0, 0, 0, "push_0100");
      applyStimulus(1, 0, 16'h0200, 0, 16'h0101, 1, 0, 0, "push_0200");
      applyStimulus(1, 0, 16'h0300, 0, 16'h0201, 2, 0, 0, "push_0300");
      applyStimulus(0, 1, 16'h0000, 0, 16'h0301, 3, 0, 0, "pop_0301");
      applyStimulus(0, 1, 16'h0000, 0, 16'h0201, 2, 0, 0, "pop_0201");
      applyStimulus(0, 1, 16'h0000, 0, 16'h0101, 1, 0, 0, "pop_0101");
      applyStimulus(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, "drained");

      applyStimulus(0, 1, 16'h0000, 0, 16'h0000, 0, 0, 0, "pop_empty");
      applyStimulus(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, "underflow_set");
      applyStimulus(0, 0, 16'h0000, 1, 16'h0000, 0, 0, 1, "clr_cycle");
      applyStimulus(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, "underflow_clr");
      applyStimulus(0, 1, 16'h0000, 1, 16'h0000, 0, 0, 0, "pop_empty_and_clr");
      applyStimulus(0, 0, 16'h0000, 1, 16'h0000, 0, 0, 1, "set_beats_clr");
      applyStimulus(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, "underflow_clr2");

      for (int k = 0; k < 9; k++) begin
         applyStimulus(1, 0, 16'(16'h1000 + k), 0,
                       (k == 0) ? 16'h0000 : 16'(16'h1000 + k), k, 0, 0, "fill_push");
      end
      for (int i = 0; i < 8; i++) begin
`ifdef RA_STACK_WRAP_EN
         applyStimulus(0, 1, 16'h0000, 0, 16'(16'h1009 - i), 8 - i, 0, 0, "wrap_pop");
`else
         applyStimulus(0, 1, 16'h0000, 0, 16'(16'h1008 - i), 8 - i, 1, 0, "drop_pop");
`endif
      end
      applyStimulus(0, 0, 16'h0000, 1, 16'h0000, 0, ovf_held, 0, "ovf_clr_cycle");
      applyStimulus(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, "ovf_cleared");

      applyStimulus(1, 0, 16'h0040, 0, 16'h0000, 0, 0, 0, "tc_push_0040");
      applyStimulus(1, 0, 16'h0050, 0, 16'h0041, 1, 0, 0, "tc_push_0050");
      applyStimulus(1, 1, 16'h0070, 0, 16'h0051, 2, 0, 0, "tail_call");
      applyStimulus(0, 1, 16'h0000, 0, 16'h0071, 2, 0, 0, "tc_pop_0071");
      applyStimulus(0, 1, 16'h0000, 0, 16'h0041, 1, 0, 0, "tc_pop_0041");
      applyStimulus(1, 1, 16'h0090, 0, 16'h0000, 0, 0, 0, "pushpop_empty");
      applyStimulus(0, 1, 16'h0000, 0, 16'h0091, 1, 0, 0, "pushpop_result");

      applyStimulus(1, 0, 16'hFFFF, 0, 16'h0000, 0, 0, 0, "push_ffff");
      applyStimulus(1, 0, 16'h0123, 0, 16'h0000, 1, 0, 0, "ffff_wraps");
      applyStimulus(0, 0, 16'h0000, 0, 16'h0124, 2, 0, 0, "before_rst");
      applyReset("async_rst");
      @(posedge clk);
      #1 rst = 1'b0;
      applyStimulus(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, "after_rst");

      repeat (2) @(posedge clk);
      if (exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
